// File: rtl/xadc_avg_filter.sv
// Per-channel moving-average filter for a 4-channel XADC sample stream.
// Each sample takes four cycles: accept, fetch oldest, update sum/history, emit.
module xadc_avg_filter #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [1:0]  s_chan,
    input  logic [11:0] s_data,
    output logic        m_valid,
    output logic [1:0]  m_chan,
    output logic [11:0] m_data,
    output logic [7:0]  duty0,
    output logic [7:0]  duty1,
    output logic [7:0]  duty2,
    output logic [7:0]  duty3
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 12 + AVG_LOG2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_EMIT   = 2'd3;

    logic [1:0]                        state_q, state_d;
    logic [1:0]                        chan_q, chan_d;
    logic [11:0]                       data_q, data_d;
    logic [11:0]                       old_q, old_d;
    logic [3:0][DEPTH-1:0][11:0]       hist_q, hist_d;
    logic [3:0][AVG_LOG2-1:0]          ptr_q, ptr_d;
    logic [3:0][SW-1:0]                sum_q, sum_d;
    logic                              m_valid_q, m_valid_d;
    logic [1:0]                        m_chan_q, m_chan_d;
    logic [11:0]                       m_data_q, m_data_d;
    logic [3:0][7:0]                   duty_q, duty_d;
    logic [SW-1:0]                     new_sum;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        data_d    = data_q;
        old_d     = old_q;
        hist_d    = hist_q;
        ptr_d     = ptr_q;
        sum_d     = sum_q;
        m_valid_d = 1'b0;
        m_chan_d  = m_chan_q;
        m_data_d  = m_data_q;
        duty_d    = duty_q;
        // Oldest sample is part of the sum, so subtracting first cannot underflow.
        new_sum   = (sum_q[chan_q] - SW'(old_q)) + SW'(data_q);

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    chan_d  = s_chan;
                    data_d  = s_data;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                old_d   = hist_q[chan_q][ptr_q[chan_q]];
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                sum_d[chan_q]                = new_sum;
                hist_d[chan_q][ptr_q[chan_q]] = data_q;
                ptr_d[chan_q]                = ptr_q[chan_q] + AVG_LOG2'(1);
                // Outputs are registered here so they appear during EMIT.
                m_valid_d                    = 1'b1;
                m_chan_d                     = chan_q;
                m_data_d                     = new_sum[SW-1:AVG_LOG2];
                duty_d[chan_q]               = new_sum[SW-1:AVG_LOG2+4];
                state_d                      = ST_EMIT;
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            data_q    <= '0;
            old_q     <= '0;
            hist_q    <= '0;
            ptr_q     <= '0;
            sum_q     <= '0;
            m_valid_q <= 1'b0;
            m_chan_q  <= '0;
            m_data_q  <= '0;
            duty_q    <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            data_q    <= data_d;
            old_q     <= old_d;
            hist_q    <= hist_d;
            ptr_q     <= ptr_d;
            sum_q     <= sum_d;
            m_valid_q <= m_valid_d;
            m_chan_q  <= m_chan_d;
            m_data_q  <= m_data_d;
            duty_q    <= duty_d;
        end
    end

    assign s_ready = (state_q == ST_IDLE);
    assign m_valid = m_valid_q;
    assign m_chan  = m_chan_q;
    assign m_data  = m_data_q;
    assign duty0   = duty_q[0];
    assign duty1   = duty_q[1];
    assign duty2   = duty_q[2];
    assign duty3   = duty_q[3];
endmodule
